// File: rtl/fan_bt_cmd_rx.sv
// fan_bt_cmd_rx: UART 8N1 receiver for the HC-06 Bluetooth link.
// Deframes bytes from RX and turns ASCII '0'..'5' into one-clock
// command pulses on blue_btn_l. The raw byte and the status strobes
// are also brought out for debug.
module fan_bt_cmd_rx #(
    parameter int CLK_HZ = 125_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       RX,
    output logic [5:0] blue_btn_l,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             rx_meta;
    logic             rx_s;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic             cnt_clr;
    logic             shift_en;
    logic             stop_sample;
    logic             start_ok;
    logic [5:0]       cmd_onehot;

    // Two-flop synchronizer; presets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // A new start bit is accepted only once the line has been seen high
    // after a frame, so a held-low line (break) does not re-trigger.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            armed <= 1'b1;
        end else if (rx_s) begin
            armed <= 1'b1;
        end else if (state == CLEANUP) begin
            armed <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s && armed) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF_END) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if ((cnt == CNT_BIT_END) && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_END) begin
                    state_next = CLEANUP;
                end
            end
            CLEANUP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: counter clear and bit-centre sampling enables.
    always_comb begin
        cnt_clr     = 1'b0;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
        start_ok    = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
            end
            START: begin
                if (cnt == CNT_HALF_END) begin
                    cnt_clr  = 1'b1;
                    start_ok = !rx_s;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_clr     = 1'b1;
                    stop_sample = 1'b1;
                end
            end
            CLEANUP: begin
                cnt_clr = 1'b1;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Bit-period counter; the half-bit offset from START carries every
    // later sample to the bit centre.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (start_ok) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // Command decode: 0x30..0x35 map to a single one-hot bit.
    always_comb begin
        cmd_onehot = '0;
        if ((shreg[7:3] == 5'b00110) && (shreg[2:0] <= 3'd5)) begin
            cmd_onehot = 6'b000001 << shreg[2:0];
        end
    end

    // Registered status strobes, captured byte and command pulses.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            blue_btn_l <= '0;
        end else begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            blue_btn_l <= '0;
            if (stop_sample) begin
                if (rx_s) begin
                    rx_data    <= shreg;
                    rx_valid   <= 1'b1;
                    blue_btn_l <= cmd_onehot;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
